// File: rtl/vec_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// vec_reg_scoreboard
//
// Issue-side hazard tracker for an 8-entry vector register file that is
// architecturally numbered 16..23. Each physical register carries a pending
// bit and a 3-bit latency countdown. A shared 8-bit slot vector reserves the
// single write port: slot[k] set means the port is taken k cycles from now.
// An instruction is accepted in the cycle it is presented if it has no
// illegal field and no RAW, WAW or write-port hazard. There is no bypass.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   issue_valid       an instruction is presented
//   issue_rs1/rs2/rd  architectural source/destination numbers (5 bits)
//   issue_use_rs1/2   source operand is read
//   issue_wr_rd       destination is written
//   issue_lat         execution latency, 1..7
//   flush             synchronous clear of all tracking state
//   issue_ready       instruction accepted this cycle (combinational)
//   illegal           presented instruction has an illegal field
//   rd1_idx/rd2_idx   physical index of rs1/rs2 (0 when out of range)
//   wb_valid, wb_idx  write-port grant and physical register written
//   inflight          number of outstanding writes, 0..8
// -----------------------------------------------------------------------------
module vec_reg_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic [4:0] issue_rd,
  input  logic       issue_use_rs1,
  input  logic       issue_use_rs2,
  input  logic       issue_wr_rd,
  input  logic [2:0] issue_lat,
  input  logic       flush,
  output logic       issue_ready,
  output logic       illegal,
  output logic [2:0] rd1_idx,
  output logic [2:0] rd2_idx,
  output logic       wb_valid,
  output logic [2:0] wb_idx,
  output logic [3:0] inflight
);

  localparam int NUM_REGS = 8;

  logic [NUM_REGS-1:0] pend;
  logic [2:0]          cnt [NUM_REGS];
  logic [7:0]          slot;

  logic       rs1_ok;
  logic       rs2_ok;
  logic       rd_ok;
  logic [2:0] wr_idx;
  logic       raw_hazard;
  logic       waw_hazard;
  logic       port_hazard;
  logic       accept_wr;
  logic [7:0] reserve;

  // Vector registers occupy 16..23, i.e. the upper two bits read 2'b10.
  function automatic logic is_vreg(input logic [4:0] r);
    return r[4:3] == 2'b10;
  endfunction

  assign rs1_ok = is_vreg(issue_rs1);
  assign rs2_ok = is_vreg(issue_rs2);
  assign rd_ok  = is_vreg(issue_rd);
  assign wr_idx = issue_rd[2:0];

  assign rd1_idx = rs1_ok ? issue_rs1[2:0] : 3'd0;
  assign rd2_idx = rs2_ok ? issue_rs2[2:0] : 3'd0;

  assign illegal = issue_valid &
                   ((issue_use_rs1 & ~rs1_ok) |
                    (issue_use_rs2 & ~rs2_ok) |
                    (issue_wr_rd   & ~rd_ok)  |
                    (issue_wr_rd   & (issue_lat == 3'd0)));

  // Pending is still set during the write-back cycle, so a dependent
  // instruction stalls through it and issues on the following cycle.
  assign raw_hazard  = (issue_use_rs1 & pend[rd1_idx]) |
                       (issue_use_rs2 & pend[rd2_idx]);
  assign waw_hazard  = issue_wr_rd & pend[wr_idx];
  assign port_hazard = issue_wr_rd & slot[issue_lat];

  assign issue_ready = issue_valid & ~illegal & ~raw_hazard & ~waw_hazard &
                       ~port_hazard & ~flush;
  assign accept_wr   = issue_ready & issue_wr_rd;
  assign reserve     = accept_wr ? (8'd1 << issue_lat) : 8'd0;

  // Slot reservation guarantees at most one register reaches cnt==1 per
  // cycle, so the scan below finds a single winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wb_valid = 1'b0;
    wb_idx   = 3'd0;
    for (int p = 0; p < NUM_REGS; p++) begin
      if (pend[p] && cnt[p] == 3'd1) begin
        wb_valid = 1'b1;
        wb_idx   = 3'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pend     <= '0;
      slot     <= '0;
      inflight <= 4'd0;
      // NOTE: cnt is a handful of flops, not a RAM, so it is reset along
      // with the rest of the tracking state.
      for (int p = 0; p < NUM_REGS; p++) cnt[p] <= 3'd0;
    end else if (flush) begin
      pend     <= '0;
      slot     <= '0;
      inflight <= 4'd0;
      for (int p = 0; p < NUM_REGS; p++) cnt[p] <= 3'd0;
    end else begin
      // Reserve at distance issue_lat as seen this cycle; the shift turns it
      // into distance issue_lat-1 as seen from the next cycle.
      slot <= (slot | reserve) >> 1;
      for (int p = 0; p < NUM_REGS; p++) begin
        if (accept_wr && wr_idx == 3'(p)) begin
          pend[p] <= 1'b1;
          cnt[p]  <= issue_lat;
        end else begin
          if (cnt[p] != 3'd0) cnt[p] <= cnt[p] - 3'd1;
          if (wb_valid && wb_idx == 3'(p)) pend[p] <= 1'b0;
        end
      end
      inflight <= inflight + {3'd0, accept_wr} - {3'd0, wb_valid};
    end
  end

endmodule

// File: tb/tb_vec_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_vec_reg_scoreboard
//
// Directed stimulus with hand-computed literal expectations, plus a
// behavioural model that tracks each outstanding write by the absolute cycle
// number at which it must write back. A compare process checks every DUT
// output against that model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_vec_reg_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic [4:0] issue_rd;
  logic       issue_use_rs1;
  logic       issue_use_rs2;
  logic       issue_wr_rd;
  logic [2:0] issue_lat;
  logic       flush;
  logic       issue_ready;
  logic       illegal;
  logic [2:0] rd1_idx;
  logic [2:0] rd2_idx;
  logic       wb_valid;
  logic [2:0] wb_idx;
  logic [3:0] inflight;

  int n_chk = 0;
  int n_err = 0;

  vec_reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_wr_rd   (issue_wr_rd),
    .issue_lat     (issue_lat),
    .flush         (flush),
    .issue_ready   (issue_ready),
    .illegal       (illegal),
    .rd1_idx       (rd1_idx),
    .rd2_idx       (rd2_idx),
    .wb_valid      (wb_valid),
    .wb_idx        (wb_idx),
    .inflight      (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: due[p] is the absolute cycle in which register p writes
  // back (0 = nothing outstanding). cyc numbers the current cycle.
  // ---------------------------------------------------------------------------
  int due [8];
  int cyc;

  function automatic bit in_rng(input logic [4:0] r);
    return (r >= 5'd16) && (r <= 5'd23);
  endfunction

  function automatic int pidx(input logic [4:0] r);
    return in_rng(r) ? int'(r) - 16 : 0;
  endfunction

  function automatic bit m_illegal();
    return issue_valid &&
           ((issue_use_rs1 && !in_rng(issue_rs1)) ||
            (issue_use_rs2 && !in_rng(issue_rs2)) ||
            (issue_wr_rd   && !in_rng(issue_rd))  ||
            (issue_wr_rd   && issue_lat == 3'd0));
  endfunction

  function automatic bit m_port_busy(input int lat);
    for (int p = 0; p < 8; p++)
      if (due[p] != 0 && due[p] == cyc + lat) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = (issue_use_rs1 && due[pidx(issue_rs1)] != 0) ||
          (issue_use_rs2 && due[pidx(issue_rs2)] != 0) ||
          (issue_wr_rd && (due[pidx(issue_rd)] != 0 || m_port_busy(int'(issue_lat))));
    return issue_valid && !m_illegal() && !haz && !flush;
  endfunction

  function automatic bit m_wb();
    for (int p = 0; p < 8; p++)
      if (due[p] != 0 && due[p] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_wb_idx();
    for (int p = 0; p < 8; p++)
      if (due[p] != 0 && due[p] == cyc) return p;
    return 0;
  endfunction

  function automatic int m_inflight();
    int n = 0;
    for (int p = 0; p < 8; p++)
      if (due[p] != 0) n++;
    return n;
  endfunction

  initial begin
    for (int p = 0; p < 8; p++) due[p] = 0;
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int p = 0; p < 8; p++) due[p] = 0;
        cyc = 0;
      end else begin
        bit acc;
        acc = m_ready() && issue_wr_rd;
        for (int p = 0; p < 8; p++)
          if (due[p] == cyc) due[p] = 0;
        if (flush) begin
          for (int p = 0; p < 8; p++) due[p] = 0;
        end else if (acc) begin
          due[pidx(issue_rd)] = cyc + int'(issue_lat);
        end
        cyc++;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_ready",    issue_ready, m_ready());
      check("cmp_illegal",  illegal,     m_illegal());
      check("cmp_rd1_idx",  rd1_idx,     pidx(issue_rs1));
      check("cmp_rd2_idx",  rd2_idx,     pidx(issue_rs2));
      check("cmp_wb_valid", wb_valid,    m_wb());
      check("cmp_wb_idx",   wb_idx,      m_wb_idx());
      check("cmp_inflight", inflight,    m_inflight());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic w, input logic [2:0] lat, input logic fl);
    issue_valid   = v;
    issue_rs1     = r1;
    issue_rs2     = r2;
    issue_rd      = rd;
    issue_use_rs1 = u1;
    issue_use_rs2 = u2;
    issue_wr_rd   = w;
    issue_lat     = lat;
    flush         = fl;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [2:0] lat);
    set_in(1'b1, 5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, lat, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_inflight", inflight, 4'd0);
    check("rst_ready",    issue_ready, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Basic latency: rd=18, lat=3, write-back in cycle 3 only.
    wr(5'd18, 3'd3);
    @(negedge clk);
    check("lat_accept",    issue_ready, 1'b1);
    check("lat_inflight0", inflight, 4'd0);
    step(); idle();
    @(negedge clk);
    check("lat_c1_inflight", inflight, 4'd1);
    check("lat_c1_wb",       wb_valid, 1'b0);
    step();
    @(negedge clk);
    check("lat_c2_wb", wb_valid, 1'b0);
    step();
    @(negedge clk);
    check("lat_c3_wb",       wb_valid, 1'b1);
    check("lat_c3_idx",      wb_idx, 3'd2);
    check("lat_c3_inflight", inflight, 4'd1);
    step();
    @(negedge clk);
    check("lat_c4_wb",       wb_valid, 1'b0);
    check("lat_c4_inflight", inflight, 4'd0);
    step();

    // RAW stall: write rd=20 lat=2, then read rs1=20.
    wr(5'd20, 3'd2);
    @(negedge clk);
    check("raw_wr_accept", issue_ready, 1'b1);
    step();
    set_in(1'b1, 5'd20, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("raw_c1_ready", issue_ready, 1'b0);
    check("raw_rd1_idx",  rd1_idx, 3'd4);
    step();
    @(negedge clk);
    check("raw_c2_ready", issue_ready, 1'b0);
    check("raw_c2_wb",    wb_valid, 1'b1);
    step();
    @(negedge clk);
    check("raw_c3_ready", issue_ready, 1'b1);
    step(); idle();
    step();

    // Port conflict: rd=16 lat=4, then rd=17 lat=3.
    wr(5'd16, 3'd4);
    @(negedge clk);
    check("port_first", issue_ready, 1'b1);
    step();
    wr(5'd17, 3'd3);
    @(negedge clk);
    check("port_c1_blocked", issue_ready, 1'b0);
    step();
    @(negedge clk);
    check("port_c2_accept", issue_ready, 1'b1);
    step(); idle();
    step();
    @(negedge clk);
    check("port_c4_wb",  wb_valid, 1'b1);
    check("port_c4_idx", wb_idx, 3'd0);
    step();
    @(negedge clk);
    check("port_c5_wb",  wb_valid, 1'b1);
    check("port_c5_idx", wb_idx, 3'd1);
    step();
    @(negedge clk);
    check("port_c6_inflight", inflight, 4'd0);
    step();

    // Illegal fields.
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("ill_rs1_illegal", illegal, 1'b1);
    check("ill_rs1_ready",   issue_ready, 1'b0);
    check("ill_rs1_idx",     rd1_idx, 3'd0);
    step();
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("ill_unused_illegal", illegal, 1'b0);
    check("ill_unused_ready",   issue_ready, 1'b1);
    step();
    wr(5'd19, 3'd0);
    @(negedge clk);
    check("ill_lat0", illegal, 1'b1);
    step();
    set_in(1'b1, 5'd16, 5'd24, 5'd16, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("ill_rs2_illegal", illegal, 1'b1);
    check("ill_rs2_idx",     rd2_idx, 3'd0);
    step();
    wr(5'd3, 3'd2);
    step();
    set_in(1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("ill_novalid", illegal, 1'b0);
    step(); idle();

    // Flush: three writes in flight, flush, reissue, flush during write-back.
    wr(5'd16, 3'd7);
    @(negedge clk);
    check("fl_w0", issue_ready, 1'b1);
    step();
    wr(5'd17, 3'd5);
    @(negedge clk);
    check("fl_w1", issue_ready, 1'b1);
    step();
    wr(5'd18, 3'd6);
    @(negedge clk);
    check("fl_w2", issue_ready, 1'b1);
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    check("fl_pre_inflight", inflight, 4'd3);
    step();
    wr(5'd16, 3'd1);
    @(negedge clk);
    check("fl_post_inflight", inflight, 4'd0);
    check("fl_reissue",       issue_ready, 1'b1);
    step();
    set_in(1'b1, 5'd0, 5'd0, 5'd19, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    @(negedge clk);
    check("fl_wb_kept",  wb_valid, 1'b1);
    check("fl_wb_idx",   wb_idx, 3'd0);
    check("fl_suppress", issue_ready, 1'b0);
    step(); idle();
    @(negedge clk);
    check("fl_after_inflight", inflight, 4'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check("fl_no_wb", wb_valid, 1'b0);
    end
    step();

    // Back-to-back lat=1 writes: accept and write-back in the same cycle.
    wr(5'd22, 3'd1);
    step();
    wr(5'd23, 3'd1);
    @(negedge clk);
    check("bb_c1_wb",       wb_valid, 1'b1);
    check("bb_c1_idx",      wb_idx, 3'd6);
    check("bb_c1_ready",    issue_ready, 1'b1);
    check("bb_c1_inflight", inflight, 4'd1);
    step(); idle();
    @(negedge clk);
    check("bb_c2_idx",      wb_idx, 3'd7);
    check("bb_c2_inflight", inflight, 4'd1);
    step();

    // WAW and RAW on rs2 against a pending rd=21.
    wr(5'd21, 3'd3);
    step();
    wr(5'd21, 3'd5);
    @(negedge clk);
    check("waw_blocked", issue_ready, 1'b0);
    step();
    set_in(1'b1, 5'd0, 5'd21, 5'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check("raw2_blocked", issue_ready, 1'b0);
    check("raw2_idx",     rd2_idx, 3'd5);
    step(); idle();
    repeat (3) step();

    // Reset mid-operation, between clock edges.
    wr(5'd17, 3'd2);
    step();
    wr(5'd19, 3'd5);
    step(); idle();
    @(negedge clk);
    check("rs_pre_wb",       wb_valid, 1'b1);
    check("rs_pre_inflight", inflight, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rs_now_wb",       wb_valid, 1'b0);
    check("rs_now_idx",      wb_idx, 3'd0);
    check("rs_now_inflight", inflight, 4'd0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check("rs_no_wb", wb_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
